// File: rtl/multi_pio_in_pkg.sv
// Shared constants, types and helpers for the multi-channel PIO input port.
// Imported by the channel slice and the Avalon-facing top level.
package multi_pio_in_pkg;

    localparam int OFF_CHANGE  = 0;
    localparam int OFF_OVERRUN = 1;
    localparam int OFF_MASK    = 2;
    localparam int OFF_INFO    = 3;

    localparam logic [7:0] INFO_VERSION = 8'h01;

    typedef enum logic {
        BANK_DATA = 1'b0,
        BANK_CTRL = 1'b1
    } bank_e;

    function automatic int idx_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 2) ? 2 : w;
    endfunction

endpackage

// File: rtl/multi_pio_in_ch.sv
// One capture channel: hold register plus CHANGE/OVERRUN flags.
// A set event in the same cycle as a clear keeps the flag asserted.
module multi_pio_in_ch
    import multi_pio_in_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stb,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_change,
    input  logic              clr_overrun,
    output logic [DATA_W-1:0] hold,
    output logic              change,
    output logic              overrun
);

    logic diff;
    logic set_ovr;
    logic change_nxt;
    logic overrun_nxt;

    assign diff    = stb && (din != hold);
    assign set_ovr = diff && change;

    always_comb begin
        change_nxt  = change;
        overrun_nxt = overrun;
        if (clr_change)
            change_nxt = 1'b0;
        if (diff)
            change_nxt = 1'b1;
        if (clr_overrun)
            overrun_nxt = 1'b0;
        if (set_ovr)
            overrun_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold    <= '0;
            change  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (stb)
                hold <= din;
            change  <= change_nxt;
            overrun <= overrun_nxt;
        end
    end

endmodule

// File: rtl/multi_pio_in.sv
// Multi-channel Avalon-MM input port with per-channel capture strobes,
// change/overrun flags, maskable level interrupt and read latency 1.
module multi_pio_in
    import multi_pio_in_pkg::*;
#(
    parameter  int DATA_W = 24,
    parameter  int NUM_CH = 4,
    localparam int IDX_W  = idx_width(NUM_CH),
    localparam int ADDR_W = IDX_W + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*DATA_W-1:0] in_port,
    input  logic [NUM_CH-1:0]        in_stb,
    input  logic [ADDR_W-1:0]        address,
    input  logic                     read,
    input  logic                     write,
    input  logic [31:0]              writedata,
    output logic [31:0]              readdata,
    output logic                     irq
);

    localparam int NSLOT = 1 << IDX_W;

    bank_e             bank;
    logic [IDX_W-1:0]  idx;
    logic              sel_change;
    logic              sel_overrun;
    logic              sel_mask;
    logic              sel_info;
    logic [NUM_CH-1:0] change;
    logic [NUM_CH-1:0] overrun;
    logic [NUM_CH-1:0] irq_mask;
    logic [NUM_CH-1:0] clr_change;
    logic [NUM_CH-1:0] clr_overrun;
    logic [DATA_W-1:0] hold_ext [NSLOT];
    logic [31:0]       rd_mux;
    logic [31:0]       info;
    logic              unused_wdata;

    assign bank = bank_e'(address[ADDR_W-1]);
    assign idx  = address[IDX_W-1:0];

    assign sel_change  = (bank == BANK_CTRL) && (idx == IDX_W'(OFF_CHANGE));
    assign sel_overrun = (bank == BANK_CTRL) && (idx == IDX_W'(OFF_OVERRUN));
    assign sel_mask    = (bank == BANK_CTRL) && (idx == IDX_W'(OFF_MASK));
    assign sel_info    = (bank == BANK_CTRL) && (idx == IDX_W'(OFF_INFO));

    assign clr_change  = (write && sel_change)  ? writedata[NUM_CH-1:0] : '0;
    assign clr_overrun = (write && sel_overrun) ? writedata[NUM_CH-1:0] : '0;

    assign info = {INFO_VERSION, 8'h00, 8'(NUM_CH), 8'(DATA_W)};

    assign unused_wdata = ^writedata[31:NUM_CH];

    // Unpopulated slots of the data bank read as zero.
    for (genvar k = 0; k < NSLOT; k++) begin : g_ch
        if (k < NUM_CH) begin : g_on
            multi_pio_in_ch #(
                .DATA_W(DATA_W)
            ) u_ch (
                .clk        (clk),
                .reset_n    (reset_n),
                .stb        (in_stb[k]),
                .din        (in_port[k*DATA_W +: DATA_W]),
                .clr_change (clr_change[k]),
                .clr_overrun(clr_overrun[k]),
                .hold       (hold_ext[k]),
                .change     (change[k]),
                .overrun    (overrun[k])
            );
        end else begin : g_off
            assign hold_ext[k] = '0;
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (bank == BANK_DATA): rd_mux = 32'(hold_ext[idx]);
            sel_change:          rd_mux = 32'(change);
            sel_overrun:         rd_mux = 32'(overrun);
            sel_mask:            rd_mux = 32'(irq_mask);
            sel_info:            rd_mux = info;
            default:             rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq_mask <= '0;
        else if (write && sel_mask)
            irq_mask <= writedata[NUM_CH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq <= 1'b0;
        else
            irq <= |(change & irq_mask);
    end

    // Mux sees pre-write state, so a same-cycle read returns the old value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            readdata <= '0;
        else if (read)
            readdata <= rd_mux;
    end

endmodule

// File: tb/tb_multi_pio_in.sv
// Scoreboard bench for multi_pio_in: default build plus a 1x32 build.
// Reads push expected words; monitors compare one cycle later.
module tb_multi_pio_in;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [95:0] in_port = '0;
    logic [3:0]  in_stb = '0;
    logic [2:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    logic        reset_n_b = 1'b0;
    logic [31:0] in_port_b = '0;
    logic [0:0]  in_stb_b = '0;
    logic [2:0]  address_b = '0;
    logic        read_b = 1'b0;
    logic        write_b = 1'b0;
    logic [31:0] writedata_b = '0;
    logic [31:0] readdata_b;
    logic        irq_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_a [$];
    logic [31:0] q_b [$];
    logic        rd_seen_a;
    logic        rd_seen_b;

    always #5 clk = ~clk;

    multi_pio_in u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_port  (in_port),
        .in_stb   (in_stb),
        .address  (address),
        .read     (read),
        .write    (write),
        .writedata(writedata),
        .readdata (readdata),
        .irq      (irq)
    );

    multi_pio_in #(
        .DATA_W(32),
        .NUM_CH(1)
    ) u_dut_b (
        .clk      (clk),
        .reset_n  (reset_n_b),
        .in_port  (in_port_b),
        .in_stb   (in_stb_b),
        .address  (address_b),
        .read     (read_b),
        .write    (write_b),
        .writedata(writedata_b),
        .readdata (readdata_b),
        .irq      (irq_b)
    );

    always @(posedge clk or negedge reset_n)
        if (!reset_n) rd_seen_a <= 1'b0;
        else          rd_seen_a <= read;

    always @(posedge clk or negedge reset_n_b)
        if (!reset_n_b) rd_seen_b <= 1'b0;
        else            rd_seen_b <= read_b;

    always @(negedge clk) begin
        logic [31:0] e;
        if (rd_seen_a) begin
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL rd_a: unexpected read data %h", readdata);
            end else begin
                e = q_a.pop_front();
                if (readdata !== e) begin
                    errors++;
                    $display("FAIL rd_a: got %h want %h", readdata, e);
                end
            end
        end
        if (rd_seen_b) begin
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL rd_b: unexpected read data %h", readdata_b);
            end else begin
                e = q_b.pop_front();
                if (readdata_b !== e) begin
                    errors++;
                    $display("FAIL rd_b: got %h want %h", readdata_b, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp);
        q_a.push_back(exp);
        address = a;
        read = 1'b1;
        tick();
        read = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic strobe(input int ch, input logic [23:0] v);
        in_port[ch*24 +: 24] = v;
        in_stb[ch] = 1'b1;
        tick();
        in_stb = '0;
    endtask

    task automatic rd_b(input logic [2:0] a, input logic [31:0] exp);
        q_b.push_back(exp);
        address_b = a;
        read_b = 1'b1;
        tick();
        read_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        reset_n_b = 1'b1;
        tick();
        chk("irq_reset", {31'd0, irq}, 32'd0);

        // Reset state
        rd(3'b111, 32'h0100_0418);
        for (int i = 0; i < 4; i++) rd(3'(i), 32'h0);
        rd(3'b100, 32'h0);
        rd(3'b101, 32'h0);
        rd(3'b110, 32'h0);

        // Capture, latency and hold
        strobe(2, 24'hABCDEF);
        rd(3'b010, 32'h00AB_CDEF);
        tick();
        tick();
        chk("rd_hold", readdata, 32'h00AB_CDEF);
        rd(3'b100, 32'h4);
        strobe(2, 24'hABCDEF);
        rd(3'b100, 32'h4);
        rd(3'b101, 32'h0);

        // Overrun and W1C
        strobe(1, 24'h000111);
        strobe(1, 24'h000222);
        rd(3'b101, 32'h2);
        rd(3'b100, 32'h6);
        wr(3'b100, 32'h2);
        wr(3'b101, 32'h2);
        rd(3'b100, 32'h4);
        rd(3'b101, 32'h0);
        wr(3'b100, 32'h4);
        rd(3'b100, 32'h0);

        // Interrupt
        wr(3'b110, 32'h1);
        rd(3'b110, 32'h1);
        strobe(3, 24'h000333);
        chk("irq_masked0", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_masked1", {31'd0, irq}, 32'd0);
        strobe(0, 24'h000005);
        chk("irq_lat0", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_set", {31'd0, irq}, 32'd1);
        wr(3'b100, 32'h1);
        chk("irq_clr_lat", {31'd0, irq}, 32'd1);
        tick();
        chk("irq_clr", {31'd0, irq}, 32'd0);
        wr(3'b110, 32'h9);
        chk("irq_mask_lat", {31'd0, irq}, 32'd0);
        tick();
        chk("irq_mask_set", {31'd0, irq}, 32'd1);

        // Set wins over same-cycle clear
        address = 3'b100;
        writedata = 32'h1;
        write = 1'b1;
        in_port[0 +: 24] = 24'h000006;
        in_stb[0] = 1'b1;
        tick();
        write = 1'b0;
        in_stb = '0;
        rd(3'b100, 32'h9);
        address = 3'b101;
        writedata = 32'h1;
        write = 1'b1;
        in_port[0 +: 24] = 24'h000007;
        in_stb[0] = 1'b1;
        tick();
        write = 1'b0;
        in_stb = '0;
        rd(3'b101, 32'h1);

        // Read and write together returns the old value
        q_a.push_back(32'h9);
        address = 3'b110;
        writedata = 32'h0;
        read = 1'b1;
        write = 1'b1;
        tick();
        read = 1'b0;
        write = 1'b0;
        rd(3'b110, 32'h0);
        tick();
        chk("irq_mask_off", {31'd0, irq}, 32'd0);

        // Read-only data bank ignores writes
        wr(3'b000, 32'hFFFF_FFFF);
        rd(3'b000, 32'h7);
        rd(3'b001, 32'h222);
        rd(3'b011, 32'h333);

        // Single 32-bit channel build
        in_port_b = 32'hDEAD_BEEF;
        in_stb_b = 1'b1;
        tick();
        in_stb_b = 1'b0;
        rd_b(3'b000, 32'hDEAD_BEEF);
        rd_b(3'b001, 32'h0);
        rd_b(3'b111, 32'h0100_0120);
        rd_b(3'b100, 32'h1);
        rd_b(3'b000, 32'hDEAD_BEEF);
        tick();

        // Async reset during a read discards it
        address_b = 3'b100;
        read_b = 1'b1;
        #2;
        reset_n_b = 1'b0;
        #1;
        chk("rst_mid_read", readdata_b, 32'h0);
        read_b = 1'b0;
        tick();
        chk("rst_hold", readdata_b, 32'h0);
        @(negedge clk);
        reset_n_b = 1'b1;
        tick();
        rd_b(3'b100, 32'h0);

        tick();
        tick();
        chk("q_a_empty", 32'(q_a.size()), 32'd0);
        chk("q_b_empty", 32'(q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
